// File: rtl/lpc_pkg.sv
// Shared LPC constants and types: Q-format, accumulator width, LFSR and sequencer encoding.
package lpc_pkg;

    localparam int unsigned ORDER    = 10;
    localparam int unsigned FRAC     = 12;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned COEF_W   = 16;
    localparam int unsigned PROD_W   = 32;
    localparam int unsigned ACC_W    = 36;
    localparam int unsigned PER_W    = 16;
    localparam int unsigned LFSR_W   = 16;
    localparam int unsigned K_W      = 4;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Feedback taps b0, b2, b3, b5
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXC  = 2'd1;
    localparam state_t ST_MAC  = 2'd2;
    localparam state_t ST_OUT  = 2'd3;

    typedef struct packed {
        logic                          voiced;
        logic [PER_W-1:0]              period;
        logic [SAMPLE_W-1:0]           gain;
        logic [ORDER-1:0][COEF_W-1:0]  a;
    } frame_t;

endpackage

// File: rtl/lpc_excitation.sv
// Excitation source: pitch counter for impulse trains, LFSR for noise, selected per sample.
module lpc_excitation
    import lpc_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       adv_i,
    input  logic                       load_i,
    input  logic [PER_W-1:0]           new_period_i,
    input  logic                       voiced_i,
    input  logic [PER_W-1:0]           period_i,
    input  logic signed [SAMPLE_W-1:0] gain_i,
    output logic signed [SAMPLE_W-1:0] exc_c_o
);

    logic [PER_W-1:0]           cnt_q, cnt_d, cnt_eff;
    logic [LFSR_W-1:0]          lfsr_q, lfsr_d;
    logic                       pulse_mode;
    logic signed [SAMPLE_W-1:0] noise_amp;

    // A load that shrinks the period below the current phase restarts the pitch cycle.
    always_comb begin
        pulse_mode = voiced_i && (period_i != PER_W'(0));
        cnt_eff    = (load_i && (cnt_q >= new_period_i)) ? '0 : cnt_q;
        noise_amp  = gain_i >>> 2;
        cnt_d      = cnt_eff;
        lfsr_d     = lfsr_q;
        exc_c_o    = '0;
        if (pulse_mode) begin
            if (cnt_eff == PER_W'(0)) begin
                exc_c_o = gain_i;
            end
            if (adv_i) begin
                cnt_d = (cnt_eff >= period_i - PER_W'(1)) ? '0 : cnt_eff + PER_W'(1);
            end
        end else begin
            exc_c_o = lfsr_q[0] ? noise_amp : -noise_amp;
            if (adv_i) begin
                lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[LFSR_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            lfsr_q <= LFSR_SEED;
        end else begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/lpc_dec.sv
// LPC synthesis decoder: excitation through a 10th-order all-pole filter, one MAC per clock.
module lpc_dec
    import lpc_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       v,
    input  logic                       load,
    input  logic signed [COEF_W-1:0]   A1,
    input  logic signed [COEF_W-1:0]   A2,
    input  logic signed [COEF_W-1:0]   A3,
    input  logic signed [COEF_W-1:0]   A4,
    input  logic signed [COEF_W-1:0]   A5,
    input  logic signed [COEF_W-1:0]   A6,
    input  logic signed [COEF_W-1:0]   A7,
    input  logic signed [COEF_W-1:0]   A8,
    input  logic signed [COEF_W-1:0]   A9,
    input  logic signed [COEF_W-1:0]   A10,
    input  logic                       voiced,
    input  logic [PER_W-1:0]           freq_count,
    input  logic signed [SAMPLE_W-1:0] gain,
    output logic signed [SAMPLE_W-1:0] y,
    output logic                       vout,
    output logic                       busy,
    output logic                       ovr
);

    state_t                     state_q, state_d;
    logic [K_W-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] e_q, e_d;
    logic signed [SAMPLE_W-1:0] hist_q [ORDER];
    logic signed [SAMPLE_W-1:0] hist_d [ORDER];
    frame_t                     act_q, act_d, shd_q, shd_d, frm_in;
    logic                       pend_q, pend_d;
    logic signed [SAMPLE_W-1:0] y_q, y_d;
    logic                       vout_q, vout_d, busy_q, busy_d, ovr_q, ovr_d;

    logic                       open_c, accept_c;
    logic signed [SAMPLE_W-1:0] exc_c, coef_c, hist_c, sat_c;
    logic signed [PROD_W-1:0]   prod_c;
    logic signed [ACC_W-1:0]    shifted_c;

    always_comb begin
        frm_in.voiced = voiced;
        frm_in.period = freq_count;
        frm_in.gain   = gain;
        frm_in.a[0]   = A1;
        frm_in.a[1]   = A2;
        frm_in.a[2]   = A3;
        frm_in.a[3]   = A4;
        frm_in.a[4]   = A5;
        frm_in.a[5]   = A6;
        frm_in.a[6]   = A7;
        frm_in.a[7]   = A8;
        frm_in.a[8]   = A9;
        frm_in.a[9]   = A10;
    end

    // OUT behaves like IDLE for requests and loads, giving back-to-back samples every 12 clocks.
    always_comb begin
        open_c   = (state_q == ST_IDLE) || (state_q == ST_OUT);
        accept_c = v && open_c;
        act_d    = act_q;
        shd_d    = shd_q;
        pend_d   = pend_q;
        if ((state_q == ST_OUT) && pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end
        if (load) begin
            if (open_c) begin
                act_d  = frm_in;
                pend_d = 1'b0;
            end else begin
                shd_d  = frm_in;
                pend_d = 1'b1;
            end
        end
    end

    lpc_excitation u_exc (
        .clk          (clk),
        .rst          (rst),
        .adv_i        (accept_c),
        .load_i       (load),
        .new_period_i (freq_count),
        .voiced_i     (act_d.voiced),
        .period_i     (act_d.period),
        .gain_i       (act_d.gain),
        .exc_c_o      (exc_c)
    );

    always_comb begin
        coef_c    = act_q.a[k_q];
        hist_c    = hist_q[k_q];
        prod_c    = coef_c * hist_c;
        shifted_c = acc_q >>> FRAC;
        if (shifted_c[ACC_W-1:SAMPLE_W-1] == {(ACC_W-SAMPLE_W+1){shifted_c[ACC_W-1]}}) begin
            sat_c = shifted_c[SAMPLE_W-1:0];
        end else begin
            sat_c = shifted_c[ACC_W-1] ? 16'sh8000 : 16'sh7FFF;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        e_d     = e_q;
        hist_d  = hist_q;
        y_d     = y_q;
        vout_d  = 1'b0;
        ovr_d   = ovr_q | (v & ~open_c);
        case (state_q)
            ST_IDLE: begin
                if (v) begin
                    e_d     = exc_c;
                    state_d = ST_EXC;
                end
            end
            ST_EXC: begin
                acc_d   = ACC_W'(e_q) <<< FRAC;
                k_d     = '0;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                acc_d = acc_q - ACC_W'(prod_c);
                if (k_q == K_W'(ORDER - 1)) begin
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: begin
                y_d    = sat_c;
                vout_d = 1'b1;
                for (int i = ORDER - 1; i > 0; i--) begin
                    hist_d[i] = hist_q[i-1];
                end
                hist_d[0] = sat_c;
                if (v) begin
                    e_d     = exc_c;
                    state_d = ST_EXC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            e_q     <= '0;
            hist_q  <= '{default: '0};
            act_q   <= '0;
            shd_q   <= '0;
            pend_q  <= 1'b0;
            y_q     <= '0;
            vout_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            e_q     <= e_d;
            hist_q  <= hist_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            y_q     <= y_d;
            vout_q  <= vout_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign y    = y_q;
    assign vout = vout_q;
    assign busy = busy_q;
    assign ovr  = ovr_q;

endmodule

// File: doc/lpc_dec.md
# lpc_dec

LPC synthesis decoder: the receive-side counterpart of the LPC encoder. It takes a frame of 10th-order predictor coefficients, a voiced/unvoiced flag, a pitch period and a gain. From these it regenerates one 16-bit speech sample per request strobe by driving an all-pole synthesis filter with an excitation signal: an impulse train when voiced, LFSR noise when unvoiced. The filter runs as a time-multiplexed single-multiplier MAC on the system clock.

## Interface
- ORDER, 10, predictor order (fixed; A1..A10 ports)
- FRAC, 12, fractional bits of coefficients (Q4.12, 4096 = 1.0)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- v  in  1  sample request strobe, one sample per accepted pulse
- load  in  1  frame strobe; latches A1..A10, voiced, freq_count, gain
- A1..A10  in  16 each  signed Q4.12 coefficients, A(z) = 1 + sum a_k z^-k
- voiced  in  1  1 = impulse excitation, 0 = noise
- freq_count  in  16  pitch period in samples (unsigned)
- gain  in  16  signed excitation amplitude
- y  out  16  signed synthesized sample
- vout  out  1  one-cycle pulse, y valid
- busy  out  1  high while a sample is being computed
- ovr  out  1  sticky: v arrived while busy; cleared only by rst

## Operation
- **Reset values:** y=0, vout=0, busy=0, ovr=0, all ten history registers 0, all active and shadow coefficients 0, voiced=0, period=0, gain=0, pitch counter 0, LFSR=16'hACE1, load-pending=0.
- **States:** IDLE -> EXC -> MAC (10 cycles, k=1..10) -> OUT -> IDLE.
  - IDLE: leaves to EXC only when v=1.
- **Excitation e**, formed from state at the accepting edge:
  - Voiced with period>=1: e = gain when the pitch counter is 0, else 0. Counter increments per accepted sample and wraps to 0 after reaching period-1.
  - period=0: treated as unvoiced.
  - Unvoiced: e = +(gain>>>2) if LFSR bit0=1, else -(gain>>>2).
- **LFSR:** 16-bit Fibonacci. feedback = b0^b2^b3^b5, next = {fb, lfsr[15:1]}. It steps once per accepted sample, after its bit0 is used. It is frozen in voiced mode.
- **Arithmetic:**
  - EXC: acc (36-bit signed) = e <<< 12.
  - MAC step k: acc -= a_k * hist[k], with a 32-bit signed product.
  - OUT: s = acc >>> 12 (floor), saturated to [-32768, 32767]. y <= s, hist shifts (hist[1] <= s).
- **Coefficient load:**
  - load in IDLE writes active registers directly.
  - load while busy writes shadow registers and sets pending. Pending is copied into the active registers on the OUT->IDLE edge.
  - load and v in the same IDLE cycle: the new values apply to that sample.
  - On any load, if pitch counter >= new period, the counter is cleared to 0.
  - Consecutive loads while busy: the last one wins.
- **Overrun:** v while busy is dropped (no extra vout) and sets ovr.
- **Reset mid-computation:** returns to IDLE at that edge. No vout is produced and pending is discarded.

## Timing
- v sampled at edge E0: EXC at E1, MAC at E2..E11, y and vout registered at E12.
- vout is high for exactly one cycle after E12. Latency is 12 clocks.
- busy goes high at E0 and low at E12 (IDLE from E12). A v at E12 is accepted, so maximum throughput is one sample per 12 clocks.
- y holds its value until the next OUT.

## Structure
- **Package lpc_pkg:** ORDER, FRAC, ACC_W=36, LFSR_SEED=16'hACE1, LFSR tap mask, and the state enum (IDLE, EXC, MAC, OUT). It is shared with the encoder-side Q-format constants.
- **Sub-module lpc_excitation:** pitch counter + LFSR + excitation mux, with an advance strobe from the sequencer.
- **Top-level lpc_dec:** sequencer, coefficient shadow/active banks, MAC, saturation and history.

## Test plan
- **Reset:** assert rst for 2 cycles -> y=0, vout=0, busy=0, ovr=0. The first voiced sample with all A=0 and gain=1000 gives y=1000.
- **Impulse train:** A all 0, voiced=1, freq_count=4, gain=1000, 8 requests -> y = 1000, 0, 0, 0, 1000, 0, 0, 0. Each vout occurs exactly 12 clocks after its v.
- **Single pole:** A1=-2048, others 0, voiced, freq_count=100, gain=4096 -> y = 4096, 2048, 1024, 512, 256.
- **Saturation:** A1=-4096, freq_count=1, gain=30000 -> y = 30000, 32767, 32767.
- **Noise:** voiced=0, A all 0, gain=4000, after reset -> y = +1000 (bit0=1), then -1000 (LFSR=16'h5670).
- **Overrun and deferred load:**
  - v pulsed at E0 and E5 -> one vout and ovr=1.
  - load of A1=-2048 at E5 -> that sample still uses the old coefficients; the next sample uses the new ones.
